// File: rtl/mcycle_writeback_unit_if.sv
// rtl/mcycle_writeback_unit_if.sv - issue/write-back bundle between decode, register file and the multi-cycle unit
// Ports (signals):
//   Start, MCycleOp, Operand1, Operand2, DestReg : issue request from decode
//   RF_WE3                                       : pipeline write enable of the register file
//   Busy, MCycle_WE3, MCycle_WA3, MCycle_WD3     : unit status and deferred write-back
// Modports: master = decode/register-file side, slave = the unit.
interface mcycle_writeback_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [3:0]       DestReg;
  logic             RF_WE3;
  logic             Busy;
  logic             MCycle_WE3;
  logic [3:0]       MCycle_WA3;
  logic [WIDTH-1:0] MCycle_WD3;

  modport master (
    output Start, MCycleOp, Operand1, Operand2, DestReg, RF_WE3,
    input  Busy, MCycle_WE3, MCycle_WA3, MCycle_WD3
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2, DestReg, RF_WE3,
    output Busy, MCycle_WE3, MCycle_WA3, MCycle_WD3
  );
endinterface

// File: rtl/mcycle_writeback_unit.sv
// rtl/mcycle_writeback_unit.sv - iterative unsigned multiply/divide with deferred register write-back
// Ports:
//   CLK    : clock, rising edge
//   RESETn : asynchronous reset, active-low
//   bus    : mcycle_writeback_unit_if.slave (issue inputs, RF_WE3, Busy and MCycle_WE3/WA3/WD3)
module mcycle_writeback_unit #(
  parameter int WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  mcycle_writeback_unit_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WB} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       op_q, op_d;
  logic [3:0]       dest_q, dest_d;
  // acc: product high half (MUL) or partial remainder (DIV)
  // lo : multiplier shifting out / product low half (MUL) or dividend shifting out / quotient (DIV)
  // opb: multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [3:0]       wa_q, wa_d;
  logic [WIDTH-1:0] wd_q, wd_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             busy;
  logic             we;

  // State register
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.Start) state_d = S_RUN;
      S_RUN:   if (count_q == LAST) state_d = S_WB;
      S_WB:    if (!bus.RF_WE3) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend on registered state only
  always_comb begin
    busy = (state_q != S_IDLE);
    we   = (state_q == S_WB);
  end

  assign bus.Busy       = busy;
  assign bus.MCycle_WE3 = we;
  assign bus.MCycle_WA3 = wa_q;
  assign bus.MCycle_WD3 = wd_q;

  // Datapath next-state
  always_comb begin
    count_d = count_q;
    op_d    = op_q;
    dest_d  = dest_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    wa_d    = wa_q;
    wd_d    = wd_q;

    // Shift-add step: add multiplicand when the current multiplier bit is set,
    // then shift {carry, acc, lo} right by one.
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    // Restoring step: bring in the next dividend bit, try to subtract the divisor.
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          op_d    = bus.MCycleOp;
          dest_d  = bus.DestReg;
          count_d = '0;
          acc_d   = '0;
          opb_d   = bus.MCycleOp[1] ? bus.Operand2 : bus.Operand1;
          lo_d    = bus.MCycleOp[1] ? bus.Operand1 : bus.Operand2;
        end
      end
      S_RUN: begin
        count_d = count_q + CW'(1);
        if (!op_q[1]) begin
          acc_d = mul_sum[WIDTH:1];
          lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
          // Remainder stays below the divisor, so it always fits WIDTH bits.
          acc_d = div_diff[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = div_shift[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        end
        if (count_q == LAST) begin
          wa_d = dest_q;
          // Low word and quotient live in lo; high word and remainder live in acc.
          wd_d = op_q[0] ? acc_d : lo_d;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      count_q <= '0;
      op_q    <= '0;
      dest_q  <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      count_q <= count_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end
endmodule

// File: tb/tb_mcycle_writeback_unit.sv
// tb/tb_mcycle_writeback_unit.sv - self-checking bench for mcycle_writeback_unit
module tb_mcycle_writeback_unit;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic RESETn;
  always #5 CLK = ~CLK;

  mcycle_writeback_unit_if #(.WIDTH(W)) bus ();

  mcycle_writeback_unit #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RESETn(RESETn),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Result from plain arithmetic
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op; RF_WE3 is high during cycles k in [rf_from, rf_from+rf_len),
  // where cycle k is the k-th cycle after the edge that samples Start.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] dest,
                        input int rf_from, input int rf_len, input bit mid_start);
    int accept_k, busy_n, we_n, first_we, lim;
    logic [31:0] wd0, exp;
    logic [3:0] wa0;
    bit stable, found;
    exp = ref_result(op, a, b);
    // Write accepted in the first WB cycle with RF_WE3 low
    found = 0;
    accept_k = 0;
    for (int k = W + 1; k < W + 3 + rf_len; k++) begin
      if (!found && !(k >= rf_from && k < rf_from + rf_len)) begin
        accept_k = k;
        found = 1;
      end
    end
    lim = accept_k + 3;

    @(negedge CLK);
    bus.Start = 1'b1; bus.MCycleOp = op; bus.Operand1 = a; bus.Operand2 = b;
    bus.DestReg = dest; bus.RF_WE3 = 1'b0;
    @(posedge CLK);
    busy_n = 0; we_n = 0; first_we = -1; stable = 1; wd0 = '0; wa0 = '0;
    for (int k = 1; k <= lim; k++) begin
      @(negedge CLK);
      if (bus.Busy) busy_n++;
      if (bus.MCycle_WE3) begin
        we_n++;
        if (first_we < 0) begin
          first_we = k; wd0 = bus.MCycle_WD3; wa0 = bus.MCycle_WA3;
        end else if (bus.MCycle_WD3 !== wd0 || bus.MCycle_WA3 !== wa0) begin
          stable = 0;
        end
      end
      bus.Start = (mid_start && k == 10);
      if (k == 1 || (mid_start && k == 10)) begin
        // Operands change after issue; the unit must use its latched copy
        bus.Operand1 = $urandom; bus.Operand2 = $urandom | 32'd1;
        bus.MCycleOp = 2'($urandom); bus.DestReg = 4'($urandom);
      end
      bus.RF_WE3 = (k >= rf_from && k < rf_from + rf_len);
    end
    bus.Start = 1'b0; bus.RF_WE3 = 1'b0;
    check({name, ".first_we"}, 64'(first_we), 64'(W + 1));
    check({name, ".we_cycles"}, 64'(we_n), 64'(accept_k - W));
    check({name, ".busy_cycles"}, 64'(busy_n), 64'(accept_k));
    check({name, ".wd"}, {32'd0, wd0}, {32'd0, exp});
    check({name, ".wa"}, {60'd0, wa0}, {60'd0, dest});
    check({name, ".stable"}, 64'(stable), 64'd1);
    check({name, ".idle"}, {63'd0, bus.Busy}, 64'd0);
  endtask

  initial begin
    int we_seen, busy_seen;
    bus.Start = 0; bus.MCycleOp = 0; bus.Operand1 = 0; bus.Operand2 = 0;
    bus.DestReg = 0; bus.RF_WE3 = 0;
    RESETn = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst.busy", {63'd0, bus.Busy}, 64'd0);
    check("rst.we", {63'd0, bus.MCycle_WE3}, 64'd0);
    check("rst.wa", {60'd0, bus.MCycle_WA3}, 64'd0);
    check("rst.wd", {32'd0, bus.MCycle_WD3}, 64'd0);
    @(negedge CLK);
    RESETn = 1'b1;

    run_op("mul7x6", 2'b00, 32'd7, 32'd6, 4'd3, 0, 0, 0);
    run_op("mulff_lo", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 0, 0, 0);
    run_op("mulff_hi", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 0, 0, 0);
    run_op("div100_7", 2'b10, 32'd100, 32'd7, 4'd1, 0, 0, 0);
    run_op("rem100_7", 2'b11, 32'd100, 32'd7, 4'd2, 0, 0, 0);
    run_op("div0", 2'b10, 32'h1234, 32'd0, 4'd9, 0, 0, 0);
    run_op("rem0", 2'b11, 32'h1234, 32'd0, 4'd10, 0, 0, 0);
    run_op("stall3", 2'b00, 32'd1000, 32'd3000, 4'd12, W + 1, 3, 0);
    run_op("stall_early", 2'b11, 32'd12345, 32'd97, 4'd4, W - 1, 3, 0);
    run_op("busy_start", 2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 4'd15, 0, 0, 1);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      int sel;
      a = $urandom;
      sel = $urandom_range(0, 3);
      b = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
      run_op($sformatf("rnd%0d", i), 2'($urandom), a, b, 4'($urandom),
             $urandom_range(W - 2, W + 2), $urandom_range(0, 4), 1'($urandom));
    end

    // Reset during RUN: the op must vanish
    @(negedge CLK);
    bus.Start = 1'b1; bus.MCycleOp = 2'b00; bus.Operand1 = 32'd9; bus.Operand2 = 32'd9;
    bus.DestReg = 4'd7;
    @(posedge CLK);
    @(negedge CLK);
    bus.Start = 1'b0;
    repeat (9) @(negedge CLK);
    RESETn = 1'b0;
    #1;
    check("midrst.busy", {63'd0, bus.Busy}, 64'd0);
    check("midrst.wd", {32'd0, bus.MCycle_WD3}, 64'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    we_seen = 0; busy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (bus.MCycle_WE3) we_seen++;
      if (bus.Busy) busy_seen++;
    end
    check("midrst.we_seen", 64'(we_seen), 64'd0);
    check("midrst.busy_seen", 64'(busy_seen), 64'd0);
    check("midrst.wa", {60'd0, bus.MCycle_WA3}, 64'd0);
    check("midrst.wd_end", {32'd0, bus.MCycle_WD3}, 64'd0);

    run_op("post_rst", 2'b10, 32'd1000, 32'd10, 4'd8, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
